dsp_config_loader: RTL and testbench

DSP_CONFIG_LOADER -- requirements
Module: dsp_config_loader

---
 rtl/dsp_config_loader.sv | 127 ++++++++++++
 tb/tb_dsp_config_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_config_loader.sv
// Serial configuration-chain loader. Accepts WORD_W-bit words from a host and
// shifts exactly CHAIN_LEN bits, MSB first, into a downstream scan chain.
module dsp_config_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [WORD_W-1:0]                  cfg_word,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    output logic                               configuration_input,
    output logic                               configuration_enable,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count
);

    localparam int unsigned BC_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_shift;
    logic [WC_W-1:0]   r_wcnt;
    logic [BC_W-1:0]   r_bit_count;

    logic [31:0]       w_remain;
    logic [WC_W-1:0]   w_load;
    logic              w_word_last;
    logic              w_chain_last;

    // Bits still owed to the chain; a short final word loads only this many,
    // so its low-order surplus bits are never shifted out.
    assign w_remain     = CHAIN_LEN - 32'(r_bit_count);
    assign w_load       = (w_remain < WORD_W) ? w_remain[WC_W-1:0] : WC_W'(WORD_W);
    assign w_word_last  = (r_wcnt == WC_W'(1));
    assign w_chain_last = ((32'(r_bit_count) + 32'd1) == CHAIN_LEN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (cfg_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_word_last) begin
                    w_next_state = w_chain_last ? DONE : FETCH;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_wcnt      <= '0;
            r_bit_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bit_count <= '0;
                    end
                end
                FETCH: begin
                    if (!abort && cfg_valid) begin
                        r_shift <= cfg_word;
                        r_wcnt  <= w_load;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        r_shift     <= r_shift << 1;
                        r_wcnt      <= r_wcnt - WC_W'(1);
                        r_bit_count <= r_bit_count + BC_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs decode registered state only; nothing flows through from inputs.
    assign cfg_ready            = (r_state == FETCH);
    assign configuration_enable = (r_state == SHIFT);
    assign configuration_input  = (r_state == SHIFT) & r_shift[WORD_W-1];
    assign busy                 = (r_state != IDLE);
    assign done                 = (r_state == DONE);
    assign bit_count            = r_bit_count;

endmodule

// File: tb/tb_dsp_config_loader.sv
// Directed bench: a small 4-bit/7-bit loader driven from a vector table plus
// multi-cycle sequences, and an 8-bit/16-bit loader for streaming throughput.
module tb_dsp_config_loader;

    logic clk;
    logic rst_n;

    logic       start_a, abort_a, cfg_valid_a;
    logic [3:0] cfg_word_a;
    logic       cfg_ready_a, cin_a, cen_a, busy_a, done_a;
    logic [2:0] bc_a;

    logic       start_b, abort_b, cfg_valid_b;
    logic [7:0] cfg_word_b;
    logic       cfg_ready_b, cin_b, cen_b, busy_b, done_b;
    logic [4:0] bc_b;

    int n_checks;
    int n_fail;

    logic [3:0] wa [2];
    logic [7:0] wb [2];

    dsp_config_loader #(.WORD_W(4), .CHAIN_LEN(7)) u_dut_a (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start_a),
        .abort                (abort_a),
        .cfg_word             (cfg_word_a),
        .cfg_valid            (cfg_valid_a),
        .cfg_ready            (cfg_ready_a),
        .configuration_input  (cin_a),
        .configuration_enable (cen_a),
        .busy                 (busy_a),
        .done                 (done_a),
        .bit_count            (bc_a)
    );

    dsp_config_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut_b (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start_b),
        .abort                (abort_b),
        .cfg_word             (cfg_word_b),
        .cfg_valid            (cfg_valid_b),
        .cfg_ready            (cfg_ready_b),
        .configuration_input  (cin_b),
        .configuration_enable (cen_b),
        .busy                 (busy_b),
        .done                 (done_b),
        .bit_count            (bc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic [3:0] word;
        logic [7:0] exp;   // {ready, enable, input, busy, done, bit_count[2:0]}
    } vec_t;

    vec_t tbl [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] outs_a();
        return {cfg_ready_a, cen_a, cin_a, busy_a, done_a, bc_a};
    endfunction

    // Runs one full load on DUT A from IDLE, stopping once DONE is observed.
    task automatic full_load_a(output logic [6:0] bits, output int en_n, output logic done_seen);
        int idx;
        bits      = '0;
        en_n      = 0;
        done_seen = 1'b0;
        idx       = 0;
        start_a   = 1'b1;
        step();
        start_a   = 1'b0;
        check("reload_bc0", 32'(bc_a), 32'd0);
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (done_a) begin
                done_seen = 1'b1;
            end else begin
                if (cen_a) begin
                    bits = {bits[5:0], cin_a};
                    en_n++;
                end
                if (cfg_ready_a && idx < 2) begin
                    cfg_word_a  = wa[idx];
                    cfg_valid_a = 1'b1;
                    idx++;
                end else begin
                    cfg_valid_a = 1'b0;
                end
                step();
            end
        end
        cfg_valid_a = 1'b0;
    endtask

    initial begin
        logic [6:0]  bits;
        logic [15:0] bb;
        int          en_n;
        int          rdy_in_shift;
        int          ib;
        logic        done_seen;
        logic        any_done;

        n_checks = 0;
        n_fail   = 0;
        wa[0] = 4'b1011;
        wa[1] = 4'b0110;
        wb[0] = 8'hA5;
        wb[1] = 8'h3C;

        //                 start abort valid  word     rdy en in bsy dn bc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, {5'b10010, 3'd0}};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'hB, {5'b01110, 3'd0}};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01010, 3'd1}};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01110, 3'd2}};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01110, 3'd3}};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b10010, 3'd4}};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'h6, {5'b01010, 3'd4}};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01110, 3'd5}};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01110, 3'd6}};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b00011, 3'd7}};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b00000, 3'd7}};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'hF, {5'b00000, 3'd7}};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'h0, {5'b10010, 3'd0}};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'h8, {5'b01110, 3'd0}};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 4'h0, {5'b01010, 3'd1}};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01010, 3'd2}};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b01010, 3'd3}};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 4'h0, {5'b10010, 3'd4}};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 4'hF, {5'b00000, 3'd4}};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 4'h0, {5'b00000, 3'd4}};

        // Reset with every other control asserted: reset must win.
        rst_n       = 1'b0;
        start_a     = 1'b1;
        abort_a     = 1'b1;
        cfg_valid_a = 1'b1;
        cfg_word_a  = 4'hF;
        start_b     = 1'b1;
        abort_b     = 1'b0;
        cfg_valid_b = 1'b1;
        cfg_word_b  = 8'hFF;
        step();
        step();
        check("reset_a", 32'(outs_a()), 32'd0);
        check("reset_b", 32'({cfg_ready_b, cen_b, cin_b, busy_b, done_b, bc_b}), 32'd0);
        rst_n       = 1'b1;
        start_a     = 1'b0;
        abort_a     = 1'b0;
        cfg_valid_a = 1'b0;
        cfg_word_a  = '0;
        start_b     = 1'b0;
        cfg_valid_b = 1'b0;
        cfg_word_b  = '0;
        step();
        check("idle_a", 32'(outs_a()), 32'd0);

        for (int v = 0; v < 20; v++) begin
            start_a     = tbl[v].start;
            abort_a     = tbl[v].abort;
            cfg_valid_a = tbl[v].valid;
            cfg_word_a  = tbl[v].word;
            step();
            check($sformatf("vec%0d", v), 32'(outs_a()), 32'(tbl[v].exp));
        end
        start_a     = 1'b0;
        abort_a     = 1'b0;
        cfg_valid_a = 1'b0;

        // Abort after the third shift of the first word.
        start_a = 1'b1;
        step();
        start_a     = 1'b0;
        cfg_valid_a = 1'b1;
        cfg_word_a  = 4'b1011;
        step();
        cfg_valid_a = 1'b0;
        step();
        step();
        step();
        check("pre_abort_bc", 32'(bc_a), 32'd3);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("abort_outs", 32'(outs_a()), 32'({5'b00000, 3'd3}));
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            any_done |= done_a;
            step();
        end
        check("abort_no_done", 32'(any_done), 32'd0);
        full_load_a(bits, en_n, done_seen);
        check("abort_reload_bits", 32'(bits), 32'(7'b1011011));
        check("abort_reload_en", 32'(en_n), 32'd7);
        check("abort_reload_done", 32'(done_seen), 32'd1);
        check("abort_reload_bc", 32'(bc_a), 32'd7);
        step();
        check("after_done_idle", 32'(outs_a()), 32'({5'b00000, 3'd7}));

        // Abort coinciding with the final shift suppresses DONE.
        start_a = 1'b1;
        step();
        start_a     = 1'b0;
        cfg_valid_a = 1'b1;
        cfg_word_a  = 4'b1011;
        step();
        cfg_valid_a = 1'b0;
        step();
        step();
        step();
        step();
        cfg_valid_a = 1'b1;
        cfg_word_a  = 4'b0110;
        step();
        cfg_valid_a = 1'b0;
        step();
        step();
        check("final_shift_bc", 32'(bc_a), 32'd6);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check("final_abort_outs", 32'(outs_a()), 32'({5'b00000, 3'd6}));
        step();
        check("final_abort_no_done", 32'(done_a), 32'd0);

        // Reset asserted mid-SHIFT, then a clean reload.
        start_a = 1'b1;
        step();
        start_a     = 1'b0;
        cfg_valid_a = 1'b1;
        cfg_word_a  = 4'b1111;
        step();
        cfg_valid_a = 1'b0;
        step();
        check("pre_reset_shift", 32'({cen_a, cin_a}), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midshift_reset", 32'(outs_a()), 32'd0);
        step();
        full_load_a(bits, en_n, done_seen);
        check("post_reset_bits", 32'(bits), 32'(7'b1011011));
        check("post_reset_en", 32'(en_n), 32'd7);
        check("post_reset_done", 32'(done_seen), 32'd1);
        step();

        // Streaming on the 8/16 instance with cfg_valid held high.
        bb           = '0;
        en_n         = 0;
        rdy_in_shift = 0;
        ib           = 0;
        start_b      = 1'b1;
        cfg_valid_b  = 1'b1;
        step();
        start_b = 1'b0;
        check("b_first_fetch", 32'({cfg_ready_b, busy_b}), 32'd3);
        for (int c = 0; c < 18; c++) begin
            if (cen_b) begin
                bb = {bb[14:0], cin_b};
                en_n++;
                if (cfg_ready_b) rdy_in_shift++;
            end
            if (cfg_ready_b && ib < 2) begin
                cfg_word_b = wb[ib];
                ib++;
            end
            step();
        end
        check("b_enable_cycles", 32'(en_n), 32'd16);
        check("b_ready_in_shift", 32'(rdy_in_shift), 32'd0);
        check("b_serial_data", 32'(bb), 32'h0000A53C);
        check("b_done", 32'(done_b), 32'd1);
        check("b_bit_count", 32'(bc_b), 32'd16);
        cfg_valid_b = 1'b0;
        step();
        check("b_idle", 32'({busy_b, done_b, bc_b}), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
